// File: rtl/block_ram_arbiter_pkg.sv
// Shared types for the two-port block RAM arbiter: requester identity and RAM command layout.
package block_ram_arb_pkg;

    localparam int RAM_ADDR_BITS_DEF = 13;
    localparam int RAM_WIDTH_DEF     = 8;

    typedef enum logic {
        OWNER_P0 = 1'b0,
        OWNER_P1 = 1'b1
    } owner_t;

    typedef struct packed {
        logic                         we;
        logic [RAM_ADDR_BITS_DEF-1:0] addr;
        logic [RAM_WIDTH_DEF-1:0]     wdata;
    } ram_cmd_t;

    // Round-robin tie-break: whoever did not own the RAM last time wins.
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWNER_P0) ? OWNER_P1 : OWNER_P0;
    endfunction

endpackage

// File: rtl/block_ram_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the block RAM arbiter.
// slave = arbiter view, master = environment (requesters plus RAM) view.
interface block_ram_arbiter_if #(
    parameter int RAM_ADDR_BITS = 13,
    parameter int RAM_WIDTH     = 8
);
    logic                     p0_write_enable;
    logic                     p0_read_enable;
    logic [RAM_ADDR_BITS-1:0] p0_address;
    logic [RAM_WIDTH-1:0]     p0_write_data;
    logic [RAM_WIDTH-1:0]     p0_read_data;
    logic                     p0_read_valid;
    logic                     p0_overflow;

    logic                     p1_req;
    logic                     p1_write_enable;
    logic [RAM_ADDR_BITS-1:0] p1_address;
    logic [RAM_WIDTH-1:0]     p1_write_data;
    logic                     p1_gnt;
    logic [RAM_WIDTH-1:0]     p1_read_data;
    logic                     p1_read_valid;

    logic                     ram_write_enable;
    logic                     ram_read_enable;
    logic [RAM_ADDR_BITS-1:0] ram_address;
    logic [RAM_WIDTH-1:0]     ram_write_data;
    logic [RAM_WIDTH-1:0]     ram_read_data;

    modport slave (
        input  p0_write_enable, p0_read_enable, p0_address, p0_write_data,
        output p0_read_data, p0_read_valid, p0_overflow,
        input  p1_req, p1_write_enable, p1_address, p1_write_data,
        output p1_gnt, p1_read_data, p1_read_valid,
        output ram_write_enable, ram_read_enable, ram_address, ram_write_data,
        input  ram_read_data
    );

    modport master (
        output p0_write_enable, p0_read_enable, p0_address, p0_write_data,
        input  p0_read_data, p0_read_valid, p0_overflow,
        output p1_req, p1_write_enable, p1_address, p1_write_data,
        input  p1_gnt, p1_read_data, p1_read_valid,
        input  ram_write_enable, ram_read_enable, ram_address, ram_write_data,
        output ram_read_data
    );

endinterface

// File: rtl/block_ram_arbiter_read_tag_pipe.sv
// Purpose: delays {valid, owner} of each issued RAM read to line up with ram_read_data.
// Latency: DEPTH cycles from in_vld to out_vld.
// Backpressure: none; one entry per cycle, always shifts.
module read_tag_pipe
    import block_ram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_vld,
    input  owner_t in_owner,
    output logic   out_vld,
    output owner_t out_owner
);

    logic [DEPTH-1:0] vld_q;
    owner_t           owner_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                owner_q[i] <= OWNER_P0;
            end
        end else begin
            vld_q[0]   <= in_vld;
            owner_q[0] <= in_owner;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]   <= vld_q[i-1];
                owner_q[i] <= owner_q[i-1];
            end
        end
    end

    assign out_vld   = vld_q[DEPTH-1];
    assign out_owner = owner_q[DEPTH-1];

endmodule

// File: rtl/block_ram_arbiter.sv
// Purpose: shares one single-port block RAM between a strobe port (p0) and a req/gnt port (p1).
// Latency: grant is combinational; p0 read returns 2+READ_LATENCY cycles after its strobe (+1 on lost tie).
// Backpressure: p1 waits on p1_gnt (max 1 cycle); p0 has a one-deep slot, excess strobes set p0_overflow.
module block_ram_arbiter
    import block_ram_arb_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 13,
    parameter int RAM_WIDTH     = 8,
    parameter int READ_LATENCY  = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    block_ram_arbiter_if.slave  bus
);

    typedef struct packed {
        logic                     we;
        logic [RAM_ADDR_BITS-1:0] addr;
        logic [RAM_WIDTH-1:0]     wdata;
    } cmd_t;

    cmd_t                     pend_cmd;
    logic                     pend_valid;
    owner_t                   last_owner;
    cmd_t                     p1_cmd;
    cmd_t                     sel_cmd;
    logic                     gnt_p0;
    logic                     gnt_p1;
    logic                     drive_en;
    logic                     p0_strobe;
    logic                     p0_accept;
    logic [RAM_ADDR_BITS-1:0] addr_q;
    logic [RAM_WIDTH-1:0]     wdata_q;
    logic                     overflow_q;
    logic [RAM_WIDTH-1:0]     p0_rd_data_q;
    logic                     p0_rd_vld_q;
    logic                     tag_in_vld;
    owner_t                   tag_in_owner;
    logic                     tag_out_vld;
    owner_t                   tag_out_owner;

    always_comb begin
        p1_cmd.we    = bus.p1_write_enable;
        p1_cmd.addr  = bus.p1_address;
        p1_cmd.wdata = bus.p1_write_data;

        gnt_p0 = pend_valid && (!bus.p1_req || other_owner(last_owner) == OWNER_P0);
        gnt_p1 = bus.p1_req && (!pend_valid || other_owner(last_owner) == OWNER_P1);

        sel_cmd = gnt_p0 ? pend_cmd : p1_cmd;
        // RAM stays quiet while held in reset even though p1_gnt may be asserted.
        drive_en = rst_n && (gnt_p0 || gnt_p1);

        p0_strobe = bus.p0_write_enable || bus.p0_read_enable;
        p0_accept = p0_strobe && (!pend_valid || gnt_p0);

        tag_in_vld   = drive_en && !sel_cmd.we;
        tag_in_owner = gnt_p0 ? OWNER_P0 : OWNER_P1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_cmd   <= '0;
            last_owner <= OWNER_P1;
            addr_q     <= '0;
            wdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (p0_accept) begin
                pend_valid     <= 1'b1;
                pend_cmd.we    <= bus.p0_write_enable;
                pend_cmd.addr  <= bus.p0_address;
                pend_cmd.wdata <= bus.p0_write_data;
            end else if (gnt_p0) begin
                pend_valid <= 1'b0;
            end

            if (p0_strobe && !p0_accept) begin
                overflow_q <= 1'b1;
            end

            if (gnt_p0) begin
                last_owner <= OWNER_P0;
            end else if (gnt_p1) begin
                last_owner <= OWNER_P1;
            end

            if (drive_en) begin
                addr_q  <= sel_cmd.addr;
                wdata_q <= sel_cmd.wdata;
            end
        end
    end

    read_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_read_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (tag_in_vld),
        .in_owner  (tag_in_owner),
        .out_vld   (tag_out_vld),
        .out_owner (tag_out_owner)
    );

    // p0 sees its data one cycle after the RAM presents it, held until the next p0 read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_rd_data_q <= '0;
            p0_rd_vld_q  <= 1'b0;
        end else begin
            p0_rd_vld_q <= tag_out_vld && (tag_out_owner == OWNER_P0);
            if (tag_out_vld && (tag_out_owner == OWNER_P0)) begin
                p0_rd_data_q <= bus.ram_read_data;
            end
        end
    end

    assign bus.p1_gnt           = gnt_p1;
    assign bus.ram_write_enable = drive_en && sel_cmd.we;
    assign bus.ram_read_enable  = drive_en && !sel_cmd.we;
    assign bus.ram_address      = drive_en ? sel_cmd.addr  : addr_q;
    assign bus.ram_write_data   = drive_en ? sel_cmd.wdata : wdata_q;

    assign bus.p1_read_data  = bus.ram_read_data;
    assign bus.p1_read_valid = rst_n && tag_out_vld && (tag_out_owner == OWNER_P1);

    assign bus.p0_read_data  = p0_rd_data_q;
    assign bus.p0_read_valid = p0_rd_vld_q;
    assign bus.p0_overflow   = overflow_q;

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Directed bench for block_ram_arbiter at READ_LATENCY 1 and 3, each behind a small RAM model.
module tb_block_ram_arbiter;

    logic clk;
    logic rst1;
    logic rst3;
    int   n_cmp;
    int   n_err;

    block_ram_arbiter_if #(.RAM_ADDR_BITS(13), .RAM_WIDTH(8)) b1 ();
    block_ram_arbiter_if #(.RAM_ADDR_BITS(13), .RAM_WIDTH(8)) b3 ();

    block_ram_arbiter #(.RAM_ADDR_BITS(13), .RAM_WIDTH(8), .READ_LATENCY(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst1),
        .bus   (b1)
    );

    block_ram_arbiter #(.RAM_ADDR_BITS(13), .RAM_WIDTH(8), .READ_LATENCY(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst3),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents: unwritten locations read a fixed pattern of their address.
    function automatic logic [7:0] dflt(input int a);
        if (a == 16) return 8'h11;
        if (a == 32) return 8'h22;
        return 8'(a) ^ 8'h5A;
    endfunction

    logic [7:0] mem1 [int];
    logic [7:0] mem3 [int];
    logic [7:0] rd1;
    logic [7:0] rd3 [3];

    always @(posedge clk) begin
        if (b1.ram_write_enable) mem1[int'(b1.ram_address)] = b1.ram_write_data;
        if (b1.ram_read_enable)
            rd1 <= mem1.exists(int'(b1.ram_address)) ? mem1[int'(b1.ram_address)] : dflt(int'(b1.ram_address));
    end

    always @(posedge clk) begin
        if (b3.ram_write_enable) mem3[int'(b3.ram_address)] = b3.ram_write_data;
        if (b3.ram_read_enable)
            rd3[0] <= mem3.exists(int'(b3.ram_address)) ? mem3[int'(b3.ram_address)] : dflt(int'(b3.ram_address));
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end

    assign b1.ram_read_data = rd1;
    assign b3.ram_read_data = rd3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        b1.p0_write_enable = 1'b0; b1.p0_read_enable = 1'b0;
        b1.p0_address = '0;        b1.p0_write_data = '0;
        b1.p1_req = 1'b0;          b1.p1_write_enable = 1'b0;
        b1.p1_address = '0;        b1.p1_write_data = '0;
        b3.p0_write_enable = 1'b0; b3.p0_read_enable = 1'b0;
        b3.p0_address = '0;        b3.p0_write_data = '0;
        b3.p1_req = 1'b0;          b3.p1_write_enable = 1'b0;
        b3.p1_address = '0;        b3.p1_write_data = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst1  = 1'b0;
        rst3  = 1'b0;
        idle();

        // Reset held 3 cycles with p1_req high.
        b1.p1_req = 1'b1;
        b3.p1_req = 1'b1;
        cyc(); settle();
        chk("rst_gnt",   32'(b1.p1_gnt), 1);
        chk("rst_we",    32'(b1.ram_write_enable), 0);
        chk("rst_re",    32'(b1.ram_read_enable), 0);
        chk("rst_addr",  32'(b1.ram_address), 0);
        chk("rst_wdata", 32'(b1.ram_write_data), 0);
        chk("rst_p0d",   32'(b1.p0_read_data), 0);
        chk("rst_p0v",   32'(b1.p0_read_valid), 0);
        chk("rst_ovf",   32'(b1.p0_overflow), 0);
        chk("rst_p1v",   32'(b1.p1_read_valid), 0);
        chk("rst3_re",   32'(b3.ram_read_enable), 0);
        cyc();
        cyc();
        rst1 = 1'b1;
        rst3 = 1'b1;
        b1.p1_req = 1'b0;
        b3.p1_req = 1'b0;
        settle();
        chk("idle_re",  32'(b1.ram_read_enable), 0);
        chk("idle_gnt", 32'(b1.p1_gnt), 0);
        cyc(); settle();
        chk("post_p1v", 32'(b1.p1_read_valid), 0);
        chk("post_p0v", 32'(b1.p0_read_valid), 0);
        cyc(); settle();
        chk("post2_p1v", 32'(b1.p1_read_valid), 0);
        chk("post2_addr", 32'(b1.ram_address), 0);

        // Port 0 write then read back.
        cyc();
        b1.p0_write_enable = 1'b1; b1.p0_address = 13'h0123; b1.p0_write_data = 8'hA5;
        settle();
        chk("w_pre_we", 32'(b1.ram_write_enable), 0);
        cyc();
        b1.p0_write_enable = 1'b0;
        settle();
        chk("w_we",    32'(b1.ram_write_enable), 1);
        chk("w_re",    32'(b1.ram_read_enable), 0);
        chk("w_addr",  32'(b1.ram_address), 32'h123);
        chk("w_wdata", 32'(b1.ram_write_data), 32'hA5);
        cyc(); settle();
        chk("w_done_we",   32'(b1.ram_write_enable), 0);
        chk("w_hold_addr", 32'(b1.ram_address), 32'h123);
        cyc();
        b1.p0_read_enable = 1'b1; b1.p0_address = 13'h0123;
        settle();
        cyc();
        b1.p0_read_enable = 1'b0;
        settle();
        chk("r_re",   32'(b1.ram_read_enable), 1);
        chk("r_addr", 32'(b1.ram_address), 32'h123);
        cyc(); settle();
        chk("r_p0v_early", 32'(b1.p0_read_valid), 0);
        chk("r_p1v_none",  32'(b1.p1_read_valid), 0);
        cyc(); settle();
        chk("r_p0v", 32'(b1.p0_read_valid), 1);
        chk("r_p0d", 32'(b1.p0_read_data), 32'hA5);
        cyc(); settle();
        chk("r_p0v_off",  32'(b1.p0_read_valid), 0);
        chk("r_p0d_hold", 32'(b1.p0_read_data), 32'hA5);

        // Contention: p1 streams reads, p0 read strobe lands in the middle.
        cyc();
        b1.p1_req = 1'b1; b1.p1_write_enable = 1'b0; b1.p1_address = 13'h0000;
        settle();
        chk("c0_gnt", 32'(b1.p1_gnt), 1);
        cyc();
        b1.p1_address = 13'h0001;
        b1.p0_read_enable = 1'b1; b1.p0_address = 13'h0040;
        settle();
        chk("c1_gnt", 32'(b1.p1_gnt), 1);
        chk("c1_p1v", 32'(b1.p1_read_valid), 1);
        chk("c1_p1d", 32'(b1.p1_read_data), 32'h5A);
        cyc();
        b1.p0_read_enable = 1'b0;
        b1.p1_address = 13'h0002;
        settle();
        chk("c2_gnt",  32'(b1.p1_gnt), 0);
        chk("c2_re",   32'(b1.ram_read_enable), 1);
        chk("c2_addr", 32'(b1.ram_address), 32'h40);
        chk("c2_p1v",  32'(b1.p1_read_valid), 1);
        chk("c2_p1d",  32'(b1.p1_read_data), 32'h5B);
        cyc(); settle();
        chk("c3_gnt",  32'(b1.p1_gnt), 1);
        chk("c3_addr", 32'(b1.ram_address), 32'h2);
        chk("c3_p1v",  32'(b1.p1_read_valid), 0);
        chk("c3_p0v",  32'(b1.p0_read_valid), 0);
        cyc();
        b1.p1_address = 13'h0003;
        settle();
        chk("c4_gnt", 32'(b1.p1_gnt), 1);
        chk("c4_p1v", 32'(b1.p1_read_valid), 1);
        chk("c4_p1d", 32'(b1.p1_read_data), 32'h58);
        chk("c4_p0v", 32'(b1.p0_read_valid), 1);
        chk("c4_p0d", 32'(b1.p0_read_data), 32'h1A);
        cyc();
        b1.p1_req = 1'b0;
        settle();
        chk("c5_p0v", 32'(b1.p0_read_valid), 0);

        // Routing: p1 read then p0 read on consecutive cycles.
        cyc();
        b1.p1_req = 1'b1; b1.p1_address = 13'h0010;
        settle();
        chk("d0_gnt", 32'(b1.p1_gnt), 1);
        cyc();
        b1.p1_req = 1'b0;
        b1.p0_read_enable = 1'b1; b1.p0_address = 13'h0020;
        settle();
        chk("d1_p1v", 32'(b1.p1_read_valid), 1);
        chk("d1_p1d", 32'(b1.p1_read_data), 32'h11);
        chk("d1_p0v", 32'(b1.p0_read_valid), 0);
        cyc();
        b1.p0_read_enable = 1'b0;
        settle();
        chk("d2_re",   32'(b1.ram_read_enable), 1);
        chk("d2_addr", 32'(b1.ram_address), 32'h20);
        chk("d2_p1v",  32'(b1.p1_read_valid), 0);
        cyc(); settle();
        chk("d3_p1v", 32'(b1.p1_read_valid), 0);
        chk("d3_p0v", 32'(b1.p0_read_valid), 0);
        chk("d3_p0d", 32'(b1.p0_read_data), 32'h1A);
        cyc(); settle();
        chk("d4_p0v", 32'(b1.p0_read_valid), 1);
        chk("d4_p0d", 32'(b1.p0_read_data), 32'h22);
        chk("d4_p1v", 32'(b1.p1_read_valid), 0);

        // Overflow: three back-to-back p0 writes against a busy p1.
        cyc();
        b1.p1_req = 1'b1; b1.p1_address = 13'h0000;
        b1.p0_write_enable = 1'b1; b1.p0_address = 13'h0100; b1.p0_write_data = 8'h77;
        settle();
        chk("e0_gnt", 32'(b1.p1_gnt), 1);
        chk("e0_ovf", 32'(b1.p0_overflow), 0);
        cyc();
        b1.p0_address = 13'h0101; b1.p0_write_data = 8'h88;
        settle();
        chk("e1_gnt",   32'(b1.p1_gnt), 0);
        chk("e1_we",    32'(b1.ram_write_enable), 1);
        chk("e1_addr",  32'(b1.ram_address), 32'h100);
        chk("e1_wdata", 32'(b1.ram_write_data), 32'h77);
        cyc();
        b1.p0_address = 13'h0102; b1.p0_write_data = 8'h99;
        settle();
        chk("e2_gnt", 32'(b1.p1_gnt), 1);
        chk("e2_ovf", 32'(b1.p0_overflow), 0);
        cyc();
        b1.p0_write_enable = 1'b0;
        settle();
        chk("e3_ovf",   32'(b1.p0_overflow), 1);
        chk("e3_gnt",   32'(b1.p1_gnt), 0);
        chk("e3_we",    32'(b1.ram_write_enable), 1);
        chk("e3_addr",  32'(b1.ram_address), 32'h101);
        chk("e3_wdata", 32'(b1.ram_write_data), 32'h88);
        cyc(); settle();
        chk("e4_gnt", 32'(b1.p1_gnt), 1);
        chk("e4_we",  32'(b1.ram_write_enable), 0);
        cyc();
        b1.p1_req = 1'b0;
        settle();
        chk("e5_we",  32'(b1.ram_write_enable), 0);
        chk("e5_re",  32'(b1.ram_read_enable), 0);
        chk("e5_ovf", 32'(b1.p0_overflow), 1);
        cyc();
        b1.p1_req = 1'b1; b1.p1_address = 13'h0101;
        settle();
        chk("e6_gnt", 32'(b1.p1_gnt), 1);
        cyc();
        b1.p1_address = 13'h0102;
        settle();
        chk("e7_p1v", 32'(b1.p1_read_valid), 1);
        chk("e7_p1d", 32'(b1.p1_read_data), 32'h88);
        cyc();
        b1.p1_req = 1'b0;
        settle();
        chk("e8_p1d", 32'(b1.p1_read_data), 32'h58);
        chk("e8_ovf", 32'(b1.p0_overflow), 1);

        // Reset with a p1 read in flight and a p0 read pending.
        cyc();
        b1.p1_req = 1'b1; b1.p1_address = 13'h0010;
        b1.p0_read_enable = 1'b1; b1.p0_address = 13'h0020;
        settle();
        chk("f0_gnt", 32'(b1.p1_gnt), 1);
        cyc();
        b1.p1_req = 1'b0; b1.p0_read_enable = 1'b0;
        rst1 = 1'b0;
        settle();
        chk("f1_p1v", 32'(b1.p1_read_valid), 0);
        chk("f1_p0v", 32'(b1.p0_read_valid), 0);
        chk("f1_re",  32'(b1.ram_read_enable), 0);
        cyc();
        rst1 = 1'b1;
        settle();
        chk("f2_p1v", 32'(b1.p1_read_valid), 0);
        chk("f2_ovf", 32'(b1.p0_overflow), 0);
        chk("f2_re",  32'(b1.ram_read_enable), 0);
        chk("f2_p0d", 32'(b1.p0_read_data), 0);
        cyc(); settle();
        chk("f3_p0v", 32'(b1.p0_read_valid), 0);
        chk("f3_p1v", 32'(b1.p1_read_valid), 0);
        chk("f3_re",  32'(b1.ram_read_enable), 0);
        cyc(); settle();
        chk("f4_p0v", 32'(b1.p0_read_valid), 0);

        // READ_LATENCY=3: p0 read latency.
        cyc();
        b3.p0_read_enable = 1'b1; b3.p0_address = 13'h0020;
        settle();
        cyc();
        b3.p0_read_enable = 1'b0;
        settle();
        chk("g1_re", 32'(b3.ram_read_enable), 1);
        cyc(); settle();
        chk("g2_p0v", 32'(b3.p0_read_valid), 0);
        cyc();
        cyc(); settle();
        chk("g4_p0v", 32'(b3.p0_read_valid), 0);
        cyc(); settle();
        chk("g5_p0v", 32'(b3.p0_read_valid), 1);
        chk("g5_p0d", 32'(b3.p0_read_data), 32'h22);

        // READ_LATENCY=3: p1 read latency.
        cyc();
        b3.p1_req = 1'b1; b3.p1_address = 13'h0010;
        settle();
        chk("h0_gnt", 32'(b3.p1_gnt), 1);
        cyc();
        b3.p1_req = 1'b0;
        settle();
        chk("h1_p1v", 32'(b3.p1_read_valid), 0);
        cyc();
        cyc(); settle();
        chk("h3_p1v", 32'(b3.p1_read_valid), 1);
        chk("h3_p1d", 32'(b3.p1_read_data), 32'h11);

        // READ_LATENCY=3: reset with a p1 read in flight.
        cyc();
        b3.p1_req = 1'b1; b3.p1_address = 13'h0010;
        settle();
        cyc();
        b3.p1_req = 1'b0;
        rst3 = 1'b0;
        settle();
        chk("k1_p1v", 32'(b3.p1_read_valid), 0);
        cyc();
        rst3 = 1'b1;
        settle();
        chk("k2_p1v", 32'(b3.p1_read_valid), 0);
        cyc(); settle();
        chk("k3_p1v", 32'(b3.p1_read_valid), 0);
        cyc(); settle();
        chk("k4_p1v", 32'(b3.p1_read_valid), 0);

        // READ_LATENCY=3: reset with a p0 read in flight.
        cyc();
        b3.p0_read_enable = 1'b1; b3.p0_address = 13'h0020;
        settle();
        cyc();
        b3.p0_read_enable = 1'b0;
        settle();
        chk("m1_re", 32'(b3.ram_read_enable), 1);
        cyc();
        rst3 = 1'b0;
        settle();
        cyc();
        rst3 = 1'b1;
        settle();
        chk("m3_p0v", 32'(b3.p0_read_valid), 0);
        cyc(); settle();
        chk("m4_p0v", 32'(b3.p0_read_valid), 0);
        cyc(); settle();
        chk("m5_p0v", 32'(b3.p0_read_valid), 0);
        cyc(); settle();
        chk("m6_p0v", 32'(b3.p0_read_valid), 0);
        chk("m6_p0d", 32'(b3.p0_read_data), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/block_ram_arbiter.md
Name: block_ram_arbiter

Overview:
- Shares one single-port block_ram between two requesters.
- Port 0 is the UART regmap side. It issues fire-and-forget single-cycle read/write strobes and has no backpressure.
- Port 1 is an on-chip client with a req/gnt handshake.
- The block buffers port 0 commands, arbitrates round-robin on conflict, drives the RAM, and routes read data back to the requester that issued each read.

Parameters:
- RAM_ADDR_BITS, 13, RAM address width.
- RAM_WIDTH, 8, data width.
- READ_LATENCY, 1, cycles from RAM read_enable to valid ram_read_data (range 1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- p0_write_enable  in  1  port 0 write strobe (one cycle)
- p0_read_enable  in  1  port 0 read strobe (one cycle)
- p0_address  in  RAM_ADDR_BITS  port 0 address, sampled with strobe
- p0_write_data  in  RAM_WIDTH  port 0 write data, sampled with strobe
- p0_read_data  out  RAM_WIDTH  last port 0 read result, held until the next one
- p0_read_valid  out  1  one-cycle pulse: p0_read_data has just been updated
- p0_overflow  out  1  sticky: a port 0 strobe was dropped
- p1_req  in  1  port 1 request, held until granted
- p1_write_enable  in  1  1=write, 0=read; valid with p1_req
- p1_address  in  RAM_ADDR_BITS  port 1 address
- p1_write_data  in  RAM_WIDTH  port 1 write data
- p1_gnt  out  1  combinational grant; the command executes this cycle
- p1_read_data  out  RAM_WIDTH  equals ram_read_data
- p1_read_valid  out  1  pulse: p1_read_data is a port 1 read result
- ram_write_enable  out  1  to block_ram
- ram_read_enable  out  1  to block_ram
- ram_address  out  RAM_ADDR_BITS  to block_ram
- ram_write_data  out  RAM_WIDTH  to block_ram
- ram_read_data  in  RAM_WIDTH  from block_ram

Behaviour:
- Single clock clk; reset is synchronous and active-low (rst_n).
- Reset values:
  - pend_valid=0, pend fields 0.
  - last_owner=P1, so port 0 wins the first tie.
  - Tag pipeline cleared.
  - p0_read_data=0, p0_read_valid=0, p0_overflow=0.
  - RAM outputs and p1_gnt are 0 while pend_valid=0 and p1_req=0.
- Port 0 capture:
  - Any strobe loads the pending slot {we, addr, wdata} at the clock edge.
  - If both strobes are high in the same cycle, the command is a write.
  - A strobe is accepted when the slot is empty, or when the slot is granted in that same cycle.
  - A strobe arriving while the slot stays occupied is dropped; the held command is kept and p0_overflow is set.
  - p0_overflow clears only on reset.
- Arbitration, evaluated combinationally each cycle:
  - Only pend_valid: grant P0. Only p1_req: grant P1.
  - Both: grant the owner not equal to last_owner.
  - last_owner is updated on every grant.
  - Worst-case wait is 1 cycle for each side.
- RAM drive:
  - The granted command is muxed onto the ram_* outputs in the same cycle.
  - Write: ram_write_enable=1, ram_read_enable=0.
  - Read: the reverse.
  - No grant: both enables 0; address and data hold their last value.
- Read return:
  - A READ_LATENCY-deep shift pipeline carries {valid, owner} for each granted read.
  - At the pipeline output, owner P1: p1_read_valid=1 in that cycle.
  - At the pipeline output, owner P0: ram_read_data is registered into p0_read_data, and p0_read_valid pulses on the following cycle, coincident with the new value.
- Port 0 read latency: strobe at cycle t, then p0_read_valid at t+2+READ_LATENCY if uncontended, one cycle later if it loses a tie.
- Writes produce no return pulse.
- Reset mid-operation: in-flight reads are discarded, with no valid pulses after reset; the pending command is lost.

Decomposition:
- Package block_ram_arb_pkg:
  - typedef enum owner_t {OWNER_P0, OWNER_P1}.
  - packed struct ram_cmd_t {we, addr, wdata}, parameterised by localparams matching the defaults.
- Sub-module read_tag_pipe (depth READ_LATENCY, carries {valid, owner}) is natural.
- The arbiter and capture logic stay in the top module.

Test Plan:
- Reset: rst_n low for 3 cycles with p1_req=1 -> all outputs 0 apart from p1_gnt; the tag pipeline is empty after release.
- P0 write then read: write 0xA5 @0x0123 at t=10, read @0x0123 at t=20 -> ram_write_enable at t=11; p0_read_data=0xA5 with p0_read_valid pulse at t=23 (READ_LATENCY=1).
- Contention: p1_req held continuously (reads @0x0000..), p0 read strobe at t=5 -> pending granted at t=6 or t=7, alternating with P1; p1_gnt is never low for 2 consecutive cycles while p1_req=1; port 0 data is correct.
- Routing: interleave a P1 read @0x0010 (data 0x11) and a P0 read @0x0020 (0x22) on consecutive cycles -> p1_read_valid carries 0x11 only; p0_read_data becomes 0x22; no cross-delivery.
- Overflow: p0 strobes on 3 consecutive cycles with p1_req=1 -> the third is dropped and p0_overflow=1, sticky until reset; the first two execute.
- Mid-flight reset: P1 read granted, rst_n=0 on the next cycle -> no p1_read_valid/p0_read_valid pulse appears; READ_LATENCY=3 rerun shows the same behaviour.
